// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the parity
// function used by both the transmitter and the receiver.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS = 8;
   localparam int unsigned UART_IDX_W     = $clog2(UART_DATA_BITS);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } uart_rx_state_t;

   // Parity bit the transmitter appends: XOR of data, inverted for odd parity.
   function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data,
                                        input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Serial line in, received byte and status pulses out.
interface uart_rx_deserializer_if;
   import uart_pkg::*;

   logic                      rx_serial;
   logic [UART_DATA_BITS-1:0] data_out;
   logic                      data_valid;
   logic                      frame_error;
   logic                      parity_error;
   logic                      busy;

   modport slave (
      input  rx_serial,
      output data_out, data_valid, frame_error, parity_error, busy
   );

   modport master (
      output rx_serial,
      input  data_out, data_valid, frame_error, parity_error, busy
   );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to 1 so an
// idle-high line never looks like a start bit coming out of reset.
module uart_rx_sync (
   input  logic clk_sis,
   input  logic rst,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_sis) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: mid-bit sampling of start, 8 data bits LSB-first, optional
// parity and stop; one-cycle result pulses with a held data_out.
module uart_rx_deserializer
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter bit          PARITY_EN    = 1'b0,
   parameter bit          PARITY_ODD   = 1'b0
) (
   input logic                    clk_sis,
   input logic                    rst,
   uart_rx_deserializer_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]      HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]      FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [UART_IDX_W-1:0] LAST_IDX = UART_IDX_W'(UART_DATA_BITS - 1);

   logic rx_s;

   uart_rx_state_t            state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [UART_IDX_W-1:0]     idx_q, idx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      par_err_q, par_err_d;
   logic [UART_DATA_BITS-1:0] data_out_q, data_out_d;
   logic                      dv_q, dv_d;
   logic                      fe_q, fe_d;
   logic                      pe_q, pe_d;
   logic                      busy_q, busy_d;

   uart_rx_sync u_sync (
      .clk_sis (clk_sis),
      .rst     (rst),
      .async_i (bus.rx_serial),
      .sync_o  (rx_s)
   );

   always_ff @(posedge clk_sis) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         par_err_q  <= 1'b0;
         data_out_q <= '0;
         dv_q       <= 1'b0;
         fe_q       <= 1'b0;
         pe_q       <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         par_err_q  <= par_err_d;
         data_out_q <= data_out_d;
         dv_q       <= dv_d;
         fe_q       <= fe_d;
         pe_q       <= pe_d;
         busy_q     <= busy_d;
      end
   end

   // Baud counter runs in every sampling state and wraps to 0 at each sample point.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      par_err_d  = par_err_q;
      data_out_d = data_out_q;
      dv_d       = 1'b0;
      fe_d       = 1'b0;
      pe_d       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d   = START;
               cnt_d     = '0;
               idx_d     = '0;
               par_err_d = 1'b0;
            end
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s;
               if (idx_q == LAST_IDX) begin
                  state_d = PARITY_EN ? PARITY : STOP;
               end else begin
                  idx_d = idx_q + UART_IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PARITY: begin
            if (cnt_q == FULL_M1) begin
               cnt_d     = '0;
               par_err_d = (rx_s != uart_parity(shift_q, PARITY_ODD));
               state_d   = STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               if (!rx_s) begin
                  fe_d    = 1'b1;
                  state_d = BREAK;
               end else if (par_err_q) begin
                  pe_d    = 1'b1;
                  state_d = IDLE;
               end else begin
                  dv_d       = 1'b1;
                  data_out_d = shift_q;
                  state_d    = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         BREAK: begin
            // A line held low after a bad stop must go high before a new start counts.
            cnt_d = '0;
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign bus.data_out     = data_out_q;
   assign bus.data_valid   = dv_q;
   assign bus.frame_error  = fe_q;
   assign bus.parity_error = pe_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: an 8N1 instance and an even-parity instance,
// with expected result pulses queued as frames are driven.
module tb_uart_rx_deserializer;

   localparam int CPB = 16;
   localparam int K_VALID  = 0;
   localparam int K_FRAME  = 1;
   localparam int K_PARITY = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;
   } exp_t;

   logic clk_sis = 1'b0;
   logic rst     = 1'b1;

   uart_rx_deserializer_if bus_a ();
   uart_rx_deserializer_if bus_p ();

   uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
      .clk_sis (clk_sis),
      .rst     (rst),
      .bus     (bus_a)
   );

   uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
      .clk_sis (clk_sis),
      .rst     (rst),
      .bus     (bus_p)
   );

   always #5 clk_sis = ~clk_sis;

   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   exp_t exp_a[$];
   exp_t exp_p[$];
   int   dv_times_a[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance n cycles, comparing every result pulse against the scoreboard.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_sis);
         cyc++;
         for (int u = 0; u < 2; u++) begin
            logic       dv, fe, pe;
            logic [7:0] dout;
            int         np, kind;
            exp_t       e;
            dv   = (u == 0) ? bus_a.data_valid   : bus_p.data_valid;
            fe   = (u == 0) ? bus_a.frame_error  : bus_p.frame_error;
            pe   = (u == 0) ? bus_a.parity_error : bus_p.parity_error;
            dout = (u == 0) ? bus_a.data_out     : bus_p.data_out;
            np   = int'(dv) + int'(fe) + int'(pe);
            if (np != 0) begin
               vectors++;
               kind = dv ? K_VALID : (fe ? K_FRAME : K_PARITY);
               if (np > 1) begin
                  miscompares++;
                  $display("FAIL pulse_overlap dut%0d cyc %0d: dv=%b fe=%b pe=%b, required at most one high",
                           u, cyc, dv, fe, pe);
               end else if ((u == 0 && exp_a.size() == 0) || (u == 1 && exp_p.size() == 0)) begin
                  miscompares++;
                  $display("FAIL unexpected_pulse dut%0d cyc %0d: kind %0d data_out %h, required no pulse",
                           u, cyc, kind, dout);
               end else begin
                  if (u == 0) e = exp_a.pop_front();
                  else        e = exp_p.pop_front();
                  if (kind !== e.kind || dout !== e.data) begin
                     miscompares++;
                     $display("FAIL result dut%0d cyc %0d: kind %0d data_out %h, required kind %0d data_out %h",
                              u, cyc, kind, dout, e.kind, e.data);
                  end
                  if (u == 0 && kind == K_VALID) dv_times_a.push_back(cyc);
               end
            end
         end
      end
   endtask

   task automatic set_line(input int u, input logic b);
      if (u == 0) bus_a.rx_serial = b;
      else        bus_p.rx_serial = b;
   endtask

   task automatic drive_bit(input int u, input logic b);
      set_line(u, b);
      tick(CPB);
   endtask

   task automatic send_frame(input int u, input logic [7:0] d, input logic stop_b,
                             input bit par_en, input logic par_b);
      drive_bit(u, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(u, d[i]);
      if (par_en) drive_bit(u, par_b);
      drive_bit(u, stop_b);
   endtask

   task automatic push_a(input int kind, input logic [7:0] d);
      exp_t e;
      e.kind = kind;
      e.data = d;
      exp_a.push_back(e);
   endtask

   task automatic push_p(input int kind, input logic [7:0] d);
      exp_t e;
      e.kind = kind;
      e.data = d;
      exp_p.push_back(e);
   endtask

   task automatic test_reset();
      logic [11:0] obs;
      rst = 1'b1;
      bus_a.rx_serial = 1'b1;
      bus_p.rx_serial = 1'b1;
      tick(3);
      for (int u = 0; u < 2; u++) begin
         obs = (u == 0) ? {bus_a.data_out, bus_a.data_valid, bus_a.frame_error, bus_a.parity_error, bus_a.busy}
                        : {bus_p.data_out, bus_p.data_valid, bus_p.frame_error, bus_p.parity_error, bus_p.busy};
         vectors++;
         if (obs !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_values dut%0d: got %h, required 000", u, obs);
         end
      end
      rst = 1'b0;
      tick(4);
   endtask

   task automatic test_single();
      push_a(K_VALID, 8'h5B);
      send_frame(0, 8'h5B, 1'b1, 1'b0, 1'b0);
      tick(8);
      vectors++;
      if (exp_a.size() != 0) begin
         miscompares++;
         $display("FAIL single_pending: %0d results outstanding, required 0", exp_a.size());
      end
      vectors++;
      if (bus_a.busy !== 1'b0 || bus_a.data_out !== 8'h5B) begin
         miscompares++;
         $display("FAIL single_after: busy %b data_out %h, required busy 0 data_out 5b",
                  bus_a.busy, bus_a.data_out);
      end
   endtask

   task automatic test_back_to_back();
      dv_times_a.delete();
      push_a(K_VALID, 8'h5B);
      push_a(K_VALID, 8'h42);
      send_frame(0, 8'h5B, 1'b1, 1'b0, 1'b0);
      send_frame(0, 8'h42, 1'b1, 1'b0, 1'b0);
      tick(8);
      vectors++;
      if (dv_times_a.size() != 2) begin
         miscompares++;
         $display("FAIL b2b_count: %0d data_valid pulses, required 2", dv_times_a.size());
      end else if (dv_times_a[1] - dv_times_a[0] != 10 * CPB) begin
         miscompares++;
         $display("FAIL b2b_spacing: %0d cycles, required %0d", dv_times_a[1] - dv_times_a[0], 10 * CPB);
      end
      vectors++;
      if (bus_a.data_out !== 8'h42) begin
         miscompares++;
         $display("FAIL b2b_data: data_out %h, required 42", bus_a.data_out);
      end
   endtask

   task automatic test_frame_error();
      push_a(K_FRAME, 8'h42);
      send_frame(0, 8'h42, 1'b0, 1'b0, 1'b0);
      tick(3 * CPB);
      vectors++;
      if (bus_a.busy !== 1'b1 || exp_a.size() != 0) begin
         miscompares++;
         $display("FAIL frame_break: busy %b outstanding %0d, required busy 1 outstanding 0",
                  bus_a.busy, exp_a.size());
      end
      set_line(0, 1'b1);
      tick(12 * CPB);
      vectors++;
      if (bus_a.busy !== 1'b0 || bus_a.data_out !== 8'h42) begin
         miscompares++;
         $display("FAIL frame_recover: busy %b data_out %h, required busy 0 data_out 42",
                  bus_a.busy, bus_a.data_out);
      end
   endtask

   task automatic test_glitch();
      set_line(0, 1'b0);
      tick(2);
      vectors++;
      if (bus_a.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL glitch_early: busy %b, required 0", bus_a.busy);
      end
      tick(1);
      vectors++;
      if (bus_a.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL glitch_detect: busy %b, required 1", bus_a.busy);
      end
      tick(1);
      set_line(0, 1'b1);
      tick(CPB / 2 - 2);
      vectors++;
      if (bus_a.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL glitch_hold: busy %b, required 1", bus_a.busy);
      end
      tick(1);
      vectors++;
      if (bus_a.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL glitch_release: busy %b, required 0", bus_a.busy);
      end
      tick(3 * CPB);
      vectors++;
      if (exp_a.size() != 0 || bus_a.data_out !== 8'h42) begin
         miscompares++;
         $display("FAIL glitch_after: outstanding %0d data_out %h, required 0 and 42",
                  exp_a.size(), bus_a.data_out);
      end
   endtask

   task automatic test_parity();
      push_p(K_VALID,  8'h5B);
      send_frame(1, 8'h5B, 1'b1, 1'b1, 1'b1);
      push_p(K_PARITY, 8'h5B);
      send_frame(1, 8'h42, 1'b1, 1'b1, 1'b1);
      push_p(K_PARITY, 8'h5B);
      send_frame(1, 8'h5B, 1'b1, 1'b1, 1'b0);
      tick(4);
      vectors++;
      if (exp_p.size() != 0 || bus_p.data_out !== 8'h5B) begin
         miscompares++;
         $display("FAIL parity_hold: outstanding %0d data_out %h, required 0 and 5b",
                  exp_p.size(), bus_p.data_out);
      end
      push_p(K_VALID, 8'h42);
      send_frame(1, 8'h42, 1'b1, 1'b1, 1'b0);
      tick(4);
      vectors++;
      if (exp_p.size() != 0 || bus_p.data_out !== 8'h42 || bus_p.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL parity_good: outstanding %0d data_out %h busy %b, required 0, 42, 0",
                  exp_p.size(), bus_p.data_out, bus_p.busy);
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0]  d;
      logic [11:0] obs;
      d = 8'h5B;
      drive_bit(0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(0, d[i]);
      set_line(0, d[4]);
      tick(CPB / 2);
      vectors++;
      if (bus_a.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL midframe_busy: busy %b, required 1", bus_a.busy);
      end
      rst = 1'b1;
      tick(1);
      obs = {bus_a.data_out, bus_a.data_valid, bus_a.frame_error, bus_a.parity_error, bus_a.busy};
      vectors++;
      if (obs !== 12'h000) begin
         miscompares++;
         $display("FAIL midframe_reset: got %h, required 000", obs);
      end
      rst = 1'b0;
      set_line(0, 1'b1);
      tick(6 * CPB);
      push_a(K_VALID, 8'h42);
      send_frame(0, 8'h42, 1'b1, 1'b0, 1'b0);
      tick(8);
      vectors++;
      if (exp_a.size() != 0 || bus_a.data_out !== 8'h42 || bus_a.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_rx: outstanding %0d data_out %h busy %b, required 0, 42, 0",
                  exp_a.size(), bus_a.data_out, bus_a.busy);
      end
   endtask

   initial begin
      bus_a.rx_serial = 1'b1;
      bus_p.rx_serial = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_frame_error();
      test_glitch();
      test_parity();
      test_reset_midframe();
      tick(20);
      vectors++;
      if (exp_a.size() != 0 || exp_p.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d/%0d results never seen, required 0/0",
                  exp_a.size(), exp_p.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Serial-to-parallel UART receiver: the far end of the link that the UART stimulus drives. It samples an asynchronous `rx_serial` line on the system clock, finds the start bit, recovers 8 data bits LSB-first at mid-bit, optionally checks parity and checks the stop bit. Each received byte is presented as a one-cycle `data_valid` pulse with `data_out`. It sits between the serial pin and the byte-level consumer logic on the `clk_sis` domain.

## Interface
- `CLKS_PER_BIT`, 16: `clk_sis` cycles per bit period; must be even, ≥ 4.
- `PARITY_EN`, 0: 1 = one parity bit follows the data bits.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity; ignored when `PARITY_EN` = 0.

- `clk_sis`  in  1  system clock; the only clock. All logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_serial`  in  1  asynchronous serial line; idles high.
- `data_out`  out  8  last good byte; holds its value until the next good byte.
- `data_valid`  out  1  one-cycle pulse; `data_out` is new on that cycle.
- `frame_error`  out  1  one-cycle pulse; stop bit sampled low.
- `parity_error`  out  1  one-cycle pulse; parity mismatch, with a good stop bit.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rx_serial` passes through a 2-flop synchronizer. Both flops reset to 1. Only the synchronized signal `rx_s` is used.
- State machine:
  - **IDLE**: `rx_s`=0 → START, bit counter cleared.
  - **START**: count to CLKS_PER_BIT/2−1 (mid start bit). If `rx_s`=0 → DATA. If `rx_s`=1, this is a false start → IDLE with no pulse.
  - **DATA**: sample `rx_s` every CLKS_PER_BIT cycles and shift it into bit[idx], idx 0..7. After bit 7, go to PARITY if PARITY_EN, else STOP.
  - **PARITY**: sample once, CLKS_PER_BIT cycles after the last data bit. Expected bit = XOR of the data bits, XOR PARITY_ODD.
  - **STOP**: sample once.
    - Sample = 1, no parity mismatch → `data_valid` pulse, `data_out` ← shift register, → IDLE.
    - Sample = 1, parity mismatch → `parity_error` pulse; `data_out` unchanged; → IDLE.
    - Sample = 0 → `frame_error` pulse; `data_out` unchanged; → BREAK.
  - **BREAK**: wait until `rx_s`=1, then → IDLE. This prevents a held-low line from being read as a new start bit.
- No ready/backpressure. A new byte overwrites `data_out`; the consumer must capture it on `data_valid`.
- Baud counter width is $clog2(CLKS_PER_BIT). It wraps to 0 on every sample point.

## Timing
- Reset values: `data_out`=8'h00, all pulses 0, `busy`=0, state IDLE, counters 0, shift register 0.
- `rst` asserted in any state returns to IDLE on the next edge. A partially received byte is discarded with no pulse.
- Start detect: `busy` rises on the edge after `rx_s` is first seen low. That is 2 cycles after `rx_serial` falls (synchronizer) plus 1 cycle.
- Sample points are measured from the start-detect edge S:
  - mid start at S + CLKS_PER_BIT/2
  - data bit k at S + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT
  - parity (if enabled) after data bit 7, then stop one bit period later
- Result pulse (`data_valid`, `frame_error` or `parity_error`) is registered: it is high on the cycle after the stop sample, together with `busy` falling.
- A start bit arriving in the same cycle the result pulse is high is detected normally. Back-to-back frames with no idle time are supported.
- At most one of the three pulses is high on any cycle.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_rx_state_t` (IDLE, START, DATA, PARITY, STOP, BREAK)
  - `UART_DATA_BITS` = 8
  - the parity function, shared with the transmitter
- Sub-module `uart_rx_sync`: 2-flop synchronizer with reset value 1, reused for other async inputs.
- Top module: FSM, baud counter, bit index counter, shift register, output registers.

## Test plan
- 8N1, CLKS_PER_BIT=16. Send 8'b01011011 (0x5B) with start 0 and stop 1 → exactly one `data_valid`, `data_out`=8'h5B, no error pulse, `busy` low afterwards.
- Back-to-back 0x5B then 0x42 with zero idle bits → two `data_valid` pulses exactly 160 cycles apart; `data_out` = 0x5B, then 0x42.
- 0x42 sent with stop bit 0 and the line held low for 3 bit times → one `frame_error`, no `data_valid`, `data_out` still holds the previous value. No new frame starts until the line returns high.
- Low glitch of 4 cycles on an idle line → `busy` pulses and returns low at mid start, with no output pulse.
- PARITY_EN=1, PARITY_ODD=0:
  - 0x5B with parity bit 1 → `data_valid`.
  - 0x5B with parity bit 0 → `parity_error`, `data_out` unchanged.
- `rst` asserted during data bit 4 of 0x5B → all outputs at reset values on the next cycle, no pulses. A following clean 0x42 is received correctly.
